// File: rtl/trena_pkg.sv
// Shared definitions for the trena control unit: state codes (also consumed
// by the 7-segment debug decoder) and the default watchdog length.
package trena_pkg;

    localparam int TIMEOUT_CICLOS_PADRAO = 2_000_000;

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARA       = 4'd1,
        MEDE          = 4'd2,
        ESPERA_MEDIDA = 4'd3,
        TRANSMITE     = 4'd4,
        ESPERA_TX     = 4'd5,
        PROXIMO       = 4'd6,
        FINAL         = 4'd7,
        ERRO          = 4'd14
    } estado_t;

endpackage

// File: rtl/trena_uc_contador_m.sv
// Modulo-M up counter with async and sync clears; fim flags the terminal count.
module contador_m #(
    parameter int M = 100,
    parameter int N = 7
) (
    input  logic clock,
    input  logic zera_as,
    input  logic zera_s,
    input  logic conta,
    output logic fim
);

    logic [N-1:0] q;

    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as)
            q <= '0;
        else if (zera_s)
            q <= '0;
        else if (conta)
            q <= (q == N'(M - 1)) ? '0 : q + 1'b1;
    end

    assign fim = (q == N'(M - 1));

endmodule

// File: rtl/trena_uc.sv
// Trena control unit: sequences one measurement and a four-character serial
// frame through the datapath handshakes, with a watchdog on both wait states.
module trena_uc
    import trena_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       medir,
    input  logic       pronto_medida,
    input  logic       pronto_transmissao,
    input  logic       fim_serial,
    output logic       zera,
    output logic       medir_fd,
    output logic       partida_serial,
    output logic       conta_ascii,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);

    estado_t estado, proximo;
    logic    wd_zera, wd_conta, wd_fim;

    // MEDE and TRANSMITE always precede the wait states, so they mark entry.
    assign wd_zera  = reset | (estado == MEDE) | (estado == TRANSMITE);
    assign wd_conta = (estado == ESPERA_MEDIDA) | (estado == ESPERA_TX);

    contador_m #(
        .M (TIMEOUT_CICLOS),
        .N ($clog2(TIMEOUT_CICLOS))
    ) u_watchdog (
        .clock   (clock),
        .zera_as (1'b0),
        .zera_s  (wd_zera),
        .conta   (wd_conta),
        .fim     (wd_fim)
    );

    always_ff @(posedge clock) begin
        if (reset)
            estado <= INICIAL;
        else
            estado <= proximo;
    end

    always_comb begin
        proximo        = INICIAL;
        zera           = 1'b0;
        medir_fd       = 1'b0;
        partida_serial = 1'b0;
        conta_ascii    = 1'b0;
        pronto         = 1'b0;
        erro           = 1'b0;
        case (estado)
            INICIAL:       proximo = medir ? PREPARA : INICIAL;
            PREPARA: begin
                zera    = 1'b1;
                proximo = MEDE;
            end
            MEDE: begin
                medir_fd = 1'b1;
                proximo  = ESPERA_MEDIDA;
            end
            // The awaited pulse is tested before expiry so it wins a tie.
            ESPERA_MEDIDA: begin
                if (pronto_medida)
                    proximo = TRANSMITE;
                else if (wd_fim)
                    proximo = ERRO;
                else
                    proximo = ESPERA_MEDIDA;
            end
            TRANSMITE: begin
                partida_serial = 1'b1;
                proximo        = ESPERA_TX;
            end
            ESPERA_TX: begin
                if (pronto_transmissao)
                    proximo = fim_serial ? FINAL : PROXIMO;
                else if (wd_fim)
                    proximo = ERRO;
                else
                    proximo = ESPERA_TX;
            end
            PROXIMO: begin
                conta_ascii = 1'b1;
                proximo     = TRANSMITE;
            end
            FINAL: begin
                pronto  = 1'b1;
                proximo = medir ? PREPARA : FINAL;
            end
            ERRO: begin
                erro    = 1'b1;
                proximo = medir ? PREPARA : ERRO;
            end
            default:       proximo = INICIAL;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: doc/trena_uc.md
# trena_uc

Control unit for the ultrasonic tape-measure (trena) datapath. On a `medir` request it clears the ASCII digit selector and triggers one HC-SR04 measurement. It then drives the 7E1 serial transmitter through the four-character frame: three digits plus terminator. It talks to the datapath only through the handshake lines below and adds a watchdog that aborts any wait that never completes.

## Interface
Parameters:
- `TIMEOUT_CICLOS`, default 2_000_000: maximum cycles spent in either wait state before abort (≈40 ms at 50 MHz).

Ports:
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `medir`  in  1  start request, level-sampled (debounced upstream).
- `pronto_medida`  in  1  datapath: measurement complete pulse.
- `pronto_transmissao`  in  1  datapath: character sent pulse.
- `fim_serial`  in  1  datapath: selector is on the last character (index 3).
- `zera`  out  1  synchronous clear of the datapath character selector.
- `medir_fd`  out  1  one-cycle measurement trigger to the datapath `medir`.
- `partida_serial`  out  1  one-cycle transmit start.
- `conta_ascii`  out  1  one-cycle selector increment.
- `pronto`  out  1  frame sent successfully.
- `erro`  out  1  watchdog abort.
- `db_estado`  out  4  current state code.

## Operation
The block is a Moore FSM: every output is decoded from the state register only. State codes:
- INICIAL=0: idle, all outputs 0. `medir`=1 → PREPARA.
- PREPARA=1: `zera`=1. → MEDE.
- MEDE=2: `medir_fd`=1. → ESPERA_MEDIDA.
- ESPERA_MEDIDA=3: `pronto_medida`=1 → TRANSMITE. Watchdog expiry → ERRO.
- TRANSMITE=4: `partida_serial`=1. → ESPERA_TX.
- ESPERA_TX=5: `pronto_transmissao`=1 and `fim_serial`=1 → FINAL. `pronto_transmissao`=1 and `fim_serial`=0 → PROXIMO. Watchdog expiry → ERRO.
- PROXIMO=6: `conta_ascii`=1. → TRANSMITE.
- FINAL=7: `pronto`=1. `medir`=1 → PREPARA; otherwise hold.
- ERRO=14: `erro`=1. `medir`=1 → PREPARA; otherwise hold.
- Unused codes → INICIAL on the next cycle.

Watchdog rules:
- The counter clears on entry to ESPERA_MEDIDA and to ESPERA_TX, and counts every cycle while in either state.
- Expiry means the count reaches `TIMEOUT_CICLOS-1` without the awaited pulse.
- If the awaited pulse and expiry occur in the same cycle, the pulse wins.

Other rules:
- `pronto_medida` and `pronto_transmissao` are ignored outside their wait states.
- A held `medir` in FINAL or ERRO restarts immediately, giving continuous back-to-back frames.
- `medir` in any other state is ignored.
- Exactly four `partida_serial` pulses and three `conta_ascii` pulses per successful frame.

## Timing
- Reset has priority over every transition.
- On reset: state=INICIAL and all outputs 0, including `db_estado`=0. The watchdog count is cleared.
- Cycle-level sequence, with `medir` sampled high at edge n:
  - n+1: PREPARA (`zera`).
  - n+2: MEDE (`medir_fd`).
  - n+3: ESPERA_MEDIDA.
- `pronto_medida` high at edge k → `partida_serial` during cycle k+1 → ESPERA_TX at k+2.
- `pronto_transmissao` high at edge t:
  - With `fim_serial`=0: `conta_ascii` during t+1, `partida_serial` during t+2. The datapath selector has already advanced before the next transmit is launched.
  - With `fim_serial`=1: `pronto`=1 from t+1.
- Minimum frame latency, `medir` to `pronto`: 3 + measurement time + 4 × (transmit time + 1) + 3 × 1 cycles.
- Reset asserted mid-frame returns the FSM to INICIAL on the next edge. The datapath selector is not cleared until the next PREPARA.

## Structure
- Package `trena_pkg`:
  - 4-bit state code constants (values above, shared with the 7-segment debug decoder).
  - `TIMEOUT_CICLOS` default.
- Sub-module: the watchdog is an instance of the existing `contador_m`, configured as follows:
  - `M=TIMEOUT_CICLOS` and `N=$clog2(TIMEOUT_CICLOS)`.
  - `zera_s` driven by the entry-to-wait decode.
  - `conta` driven by (state==ESPERA_MEDIDA or ESPERA_TX).
  - `zera_as` tied to 0.
  - `fim` used as the expiry flag.
- State register plus next-state logic plus output decode in `trena_uc`.

## Test plan
- Reset: hold `reset` 2 cycles with `medir`=1 → all outputs 0, `db_estado`=0. Release → `zera` one cycle later, `db_estado`=1.
- Nominal frame, `TIMEOUT_CICLOS`=100: `pronto_medida` 20 cycles after `medir_fd`. Each `pronto_transmissao` comes 10 cycles after `partida_serial`, with `fim_serial` high on the 4th → 4 `partida_serial`, 3 `conta_ascii`, then `pronto`=1 and `db_estado`=7, held until `medir`.
- Measurement timeout, `TIMEOUT_CICLOS`=100: no `pronto_medida` → `erro`=1, `db_estado`=14, exactly 100 cycles after entering ESPERA_MEDIDA. No `partida_serial` is ever issued.
- Transmit timeout: `pronto_transmissao` missing on the 2nd character → ERRO after 100 cycles in ESPERA_TX. Then `medir`=1 → `zera` on the next cycle.
- Simultaneous: `pronto_medida` on the exact expiry cycle → TRANSMITE, not ERRO.
- Reset mid-frame, during ESPERA_TX of character 2 → INICIAL next cycle. Spurious `pronto_transmissao` afterwards causes no output activity.
